// File: rtl/alarm_editor.sv
// Key-driven editor for the three alarm slots: holds committed H/M/S per slot,
// edits a shadow copy and drives the display with the shadow plus a blink phase.
module alarm_editor #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_CYC   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       key_clr,
  output logic [5:0] alarm1_hour,
  output logic [5:0] alarm1_minute,
  output logic [5:0] alarm1_second,
  output logic [5:0] alarm2_hour,
  output logic [5:0] alarm2_minute,
  output logic [5:0] alarm2_second,
  output logic [5:0] alarm3_hour,
  output logic [5:0] alarm3_minute,
  output logic [5:0] alarm3_second,
  output logic       edit_active,
  output logic [1:0] edit_slot,
  output logic [1:0] edit_field,
  output logic [5:0] edit_hour,
  output logic [5:0] edit_minute,
  output logic [5:0] edit_second,
  output logic       blink
);

  // Handshake: keys are single-cycle strobes with no back-pressure; every
  // strobe sampled at a rising edge is consumed on that edge, none are queued.

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic {IDLE, EDIT} state_t;

  state_t          state;
  logic [5:0]      c_hour   [1:3];
  logic [5:0]      c_minute [1:3];
  logic [5:0]      c_second [1:3];
  logic [TW-1:0]   tcnt;
  logic [BW-1:0]   bcnt;
  logic            any_key;
  logic            timeout_hit;
  logic            blink_wrap;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  assign any_key     = key_mode | key_sel | key_inc | key_dec | key_clr;
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 2));
  assign blink_wrap  = (bcnt == BW'(BLINK_CYC - 1));
  assign edit_active = (state == EDIT);

  assign alarm1_hour   = c_hour[1];
  assign alarm1_minute = c_minute[1];
  assign alarm1_second = c_second[1];
  assign alarm2_hour   = c_hour[2];
  assign alarm2_minute = c_minute[2];
  assign alarm2_second = c_second[2];
  assign alarm3_hour   = c_hour[3];
  assign alarm3_minute = c_minute[3];
  assign alarm3_second = c_second[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      edit_slot   <= 2'd0;
      edit_field  <= 2'd0;
      edit_hour   <= 6'd0;
      edit_minute <= 6'd0;
      edit_second <= 6'd0;
      blink       <= 1'b0;
      tcnt        <= '0;
      bcnt        <= '0;
      for (int i = 1; i <= 3; i++) begin
        c_hour[i]   <= 6'd0;
        c_minute[i] <= 6'd0;
        c_second[i] <= 6'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (key_mode) begin
            state       <= EDIT;
            edit_slot   <= 2'd1;
            edit_field  <= 2'd0;
            edit_hour   <= c_hour[1];
            edit_minute <= c_minute[1];
            edit_second <= c_second[1];
            blink       <= 1'b1;
            tcnt        <= '0;
            bcnt        <= '0;
          end
        end
        EDIT: begin
          if (any_key) begin
            tcnt  <= '0;
            bcnt  <= '0;
            blink <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (blink_wrap) begin
              bcnt  <= '0;
              blink <= ~blink;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end

          if (key_mode) begin
            c_hour[edit_slot]   <= edit_hour;
            c_minute[edit_slot] <= edit_minute;
            c_second[edit_slot] <= edit_second;
            if (edit_slot == 2'd3) begin
              state       <= IDLE;
              edit_slot   <= 2'd0;
              edit_field  <= 2'd0;
              edit_hour   <= 6'd0;
              edit_minute <= 6'd0;
              edit_second <= 6'd0;
              blink       <= 1'b0;
            end else begin
              // Reload reads the next slot's old value; only the current slot is written here.
              edit_slot   <= edit_slot + 2'd1;
              edit_field  <= 2'd0;
              edit_hour   <= c_hour[edit_slot + 2'd1];
              edit_minute <= c_minute[edit_slot + 2'd1];
              edit_second <= c_second[edit_slot + 2'd1];
            end
          end else if (key_clr) begin
            edit_hour   <= 6'd0;
            edit_minute <= 6'd0;
            edit_second <= 6'd0;
          end else if (key_sel) begin
            edit_field <= (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
          end else if (key_inc) begin
            case (edit_field)
              2'd0:    edit_hour   <= wrap_inc(edit_hour, 6'd23);
              2'd1:    edit_minute <= wrap_inc(edit_minute, 6'd59);
              default: edit_second <= wrap_inc(edit_second, 6'd59);
            endcase
          end else if (key_dec) begin
            case (edit_field)
              2'd0:    edit_hour   <= wrap_dec(edit_hour, 6'd23);
              2'd1:    edit_minute <= wrap_dec(edit_minute, 6'd59);
              default: edit_second <= wrap_dec(edit_second, 6'd59);
            endcase
          end else if (timeout_hit) begin
            state       <= IDLE;
            edit_slot   <= 2'd0;
            edit_field  <= 2'd0;
            edit_hour   <= 6'd0;
            edit_minute <= 6'd0;
            edit_second <= 6'd0;
            blink       <= 1'b0;
            tcnt        <= '0;
            bcnt        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_editor.sv
// Randomized bench for alarm_editor against a cycle-level reference model of
// the editing rules, plus directed scenarios with constant expectations.
module tb_alarm_editor;

  localparam int TO = 20;
  localparam int BL = 4;

  localparam logic [4:0] K_MODE = 5'b10000;
  localparam logic [4:0] K_CLR  = 5'b01000;
  localparam logic [4:0] K_SEL  = 5'b00100;
  localparam logic [4:0] K_INC  = 5'b00010;
  localparam logic [4:0] K_DEC  = 5'b00001;
  localparam logic [4:0] K_NONE = 5'b00000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_mode = 1'b0, key_sel = 1'b0, key_inc = 1'b0, key_dec = 1'b0, key_clr = 1'b0;
  logic [5:0] alarm1_hour, alarm1_minute, alarm1_second;
  logic [5:0] alarm2_hour, alarm2_minute, alarm2_second;
  logic [5:0] alarm3_hour, alarm3_minute, alarm3_second;
  logic       edit_active;
  logic [1:0] edit_slot, edit_field;
  logic [5:0] edit_hour, edit_minute, edit_second;
  logic       blink;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_com [1:3][3];
  int m_sh  [3];
  bit m_edit;
  int m_slot, m_field, m_idle, m_since;

  alarm_editor #(.TIMEOUT_CYC(TO), .BLINK_CYC(BL)) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .key_dec(key_dec), .key_clr(key_clr),
    .alarm1_hour(alarm1_hour), .alarm1_minute(alarm1_minute), .alarm1_second(alarm1_second),
    .alarm2_hour(alarm2_hour), .alarm2_minute(alarm2_minute), .alarm2_second(alarm2_second),
    .alarm3_hour(alarm3_hour), .alarm3_minute(alarm3_minute), .alarm3_second(alarm3_second),
    .edit_active(edit_active), .edit_slot(edit_slot), .edit_field(edit_field),
    .edit_hour(edit_hour), .edit_minute(edit_minute), .edit_second(edit_second),
    .blink(blink)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int field_mod(input int f);
    return (f == 0) ? 24 : 60;
  endfunction

  task automatic model_step(input bit r, input logic [4:0] k);
    if (r) begin
      for (int s = 1; s <= 3; s++) for (int f = 0; f < 3; f++) m_com[s][f] = 0;
      m_edit = 0;
      return;
    end
    if (!m_edit) begin
      if (k[4]) begin
        m_edit = 1; m_slot = 1; m_field = 0; m_idle = 0; m_since = 0;
        for (int f = 0; f < 3; f++) m_sh[f] = m_com[1][f];
      end
      return;
    end
    if (k != 0) begin
      m_idle = 0; m_since = 0;
    end else begin
      m_idle++; m_since++;
    end
    if (k[4]) begin
      for (int f = 0; f < 3; f++) m_com[m_slot][f] = m_sh[f];
      if (m_slot == 3) m_edit = 0;
      else begin
        m_slot++; m_field = 0;
        for (int f = 0; f < 3; f++) m_sh[f] = m_com[m_slot][f];
      end
    end else if (k[3]) begin
      for (int f = 0; f < 3; f++) m_sh[f] = 0;
    end else if (k[2]) begin
      m_field = (m_field + 1) % 3;
    end else if (k[1]) begin
      m_sh[m_field] = (m_sh[m_field] + 1) % field_mod(m_field);
    end else if (k[0]) begin
      m_sh[m_field] = (m_sh[m_field] + field_mod(m_field) - 1) % field_mod(m_field);
    end else if (m_idle == TO - 1) begin
      m_edit = 0;
    end
  endtask

  task automatic check_outputs();
    check("a1h", alarm1_hour, m_com[1][0]);
    check("a1m", alarm1_minute, m_com[1][1]);
    check("a1s", alarm1_second, m_com[1][2]);
    check("a2h", alarm2_hour, m_com[2][0]);
    check("a2m", alarm2_minute, m_com[2][1]);
    check("a2s", alarm2_second, m_com[2][2]);
    check("a3h", alarm3_hour, m_com[3][0]);
    check("a3m", alarm3_minute, m_com[3][1]);
    check("a3s", alarm3_second, m_com[3][2]);
    check("active", edit_active, m_edit ? 1 : 0);
    check("slot", edit_slot, m_edit ? m_slot : 0);
    check("field", edit_field, m_edit ? m_field : 0);
    check("eh", edit_hour, m_edit ? m_sh[0] : 0);
    check("em", edit_minute, m_edit ? m_sh[1] : 0);
    check("es", edit_second, m_edit ? m_sh[2] : 0);
    check("blink", blink, (m_edit && ((m_since / BL) % 2 == 0)) ? 1 : 0);
  endtask

  // driver: called just after a falling edge; applies inputs for one rising edge
  task automatic step(input bit r, input logic [4:0] k);
    rst = r;
    {key_mode, key_clr, key_sel, key_inc, key_dec} = k;
    @(posedge clk);
    model_step(r, k);
    @(negedge clk);
    rst = 1'b0;
    {key_mode, key_clr, key_sel, key_inc, key_dec} = K_NONE;
    check_outputs();
  endtask

  task automatic keys(input logic [4:0] k, input int n);
    for (int i = 0; i < n; i++) step(1'b0, k);
  endtask

  initial begin
    int quiet;
    @(negedge clk);

    // reset state and entry
    step(1'b1, K_NONE);
    check("rst_active", edit_active, 0);
    step(1'b0, K_MODE);
    check("enter_slot", edit_slot, 1);
    check("enter_blink", blink, 1);

    // wrap behaviour on each field
    step(1'b0, K_DEC);  check("hour_dec_wrap", edit_hour, 23);
    step(1'b0, K_INC);  check("hour_inc_wrap", edit_hour, 0);
    step(1'b0, K_SEL);
    step(1'b0, K_DEC);  check("min_dec_wrap", edit_minute, 59);
    step(1'b0, K_SEL);
    keys(K_INC, 60);    check("sec_inc_wrap", edit_second, 0);

    // commit 07:30:00 into slot 1, walk through remaining slots
    step(1'b1, K_NONE);
    step(1'b0, K_MODE);
    keys(K_INC, 7);
    step(1'b0, K_SEL);
    keys(K_INC, 30);
    step(1'b0, K_MODE);
    check("commit_a1h", alarm1_hour, 7);
    check("commit_a1m", alarm1_minute, 30);
    check("commit_slot2", edit_slot, 2);
    check("reload_eh", edit_hour, 0);
    keys(K_MODE, 2);
    check("exit_active", edit_active, 0);
    check("a2h_kept", alarm2_hour, 0);
    check("a1h_kept", alarm1_hour, 7);

    // timeout discards the shadow
    step(1'b1, K_NONE);
    step(1'b0, K_MODE);
    keys(K_INC, 3);
    keys(K_NONE, 18);
    check("to_not_yet", edit_active, 1);
    keys(K_NONE, 1);
    check("to_expired", edit_active, 0);
    check("to_a1h", alarm1_hour, 0);
    step(1'b0, K_MODE);
    keys(K_INC, 3);
    keys(K_NONE, 14);
    step(1'b0, K_SEL);
    keys(K_NONE, 4);
    check("to_restarted", edit_active, 1);

    // same-cycle priority
    step(1'b1, K_NONE);
    step(1'b0, K_MODE);
    keys(K_INC, 5);
    step(1'b0, K_MODE | K_INC);
    check("prio_mode_a1h", alarm1_hour, 5);
    keys(K_INC, 2);
    step(1'b0, K_CLR | K_INC);
    check("prio_clr_eh", edit_hour, 0);

    // blink phase and forced restart, then reset mid-edit
    step(1'b1, K_NONE);
    step(1'b0, K_MODE);
    keys(K_NONE, 3);
    check("blink_hold", blink, 1);
    keys(K_NONE, 1);
    check("blink_toggle", blink, 0);
    keys(K_NONE, 2);
    step(1'b0, K_SEL);
    check("blink_forced", blink, 1);
    step(1'b1, K_NONE);
    check("rst_mid_edit", edit_active, 0);

    // randomized traffic against the model
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, K_NONE);
      end else if (quiet > 0) begin
        quiet--;
        step(1'b0, K_NONE);
      end else begin
        case ($urandom_range(0, 19))
          0:               begin quiet = $urandom_range(5, 25); step(1'b0, K_NONE); end
          1:               step(1'b0, 5'($urandom_range(1, 31)));
          2:               step(1'b0, K_MODE);
          3:               step(1'b0, K_CLR);
          4, 5:            step(1'b0, K_SEL);
          6, 7, 8, 9:      step(1'b0, K_INC);
          10, 11, 12, 13:  step(1'b0, K_DEC);
          default:         step(1'b0, K_NONE);
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_editor.md
# alarm_editor

Key-driven editor that writes the three alarm time registers (hour/minute/second per slot) consumed by the alarm comparator. It sits between the debounced key front-end and the alarm comparison logic. It holds the committed alarm values, edits a shadow copy, and exposes the shadow plus a blink strobe to the display mux. A slot committed as 00:00:00 is the "alarm disabled" encoding.

## Interface
- TIMEOUT_CYC, 500_000_000: idle cycles in EDIT before edits are discarded (10 s at 50 MHz); must be ≥2.
- BLINK_CYC, 25_000_000: half-period of blink in cycles; must be ≥1.
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- key_mode  input  1  single-cycle pulse (debounced upstream): enter edit / commit current slot.
- key_sel  input  1  pulse: advance edited field H→M→S→H.
- key_inc  input  1  pulse: increment edited field.
- key_dec  input  1  pulse: decrement edited field.
- key_clr  input  1  pulse: set shadow to 00:00:00 (disables the slot once committed).
- alarm1_hour, alarm1_minute, alarm1_second  output  6 each  committed slot 1, binary.
- alarm2_hour, alarm2_minute, alarm2_second  output  6 each  committed slot 2.
- alarm3_hour, alarm3_minute, alarm3_second  output  6 each  committed slot 3.
- edit_active  output  1  high in EDIT.
- edit_slot  output  2  slot being edited: 1..3; 0 in IDLE.
- edit_field  output  2  0 = hour, 1 = minute, 2 = second; 0 in IDLE.
- edit_hour, edit_minute, edit_second  output  6 each  shadow values; 0 in IDLE.
- blink  output  1  display blink phase for the edited field; 0 in IDLE.

## Operation
- States: IDLE, EDIT.
- IDLE → EDIT on key_mode.
  - slot = 1, field = hour.
  - Shadow loaded from committed slot 1.
  - Timeout counter cleared.
- Key priority within one cycle: key_mode > key_clr > key_sel > key_inc > key_dec. Only the highest-priority key acts; the others are ignored.
- key_mode in EDIT:
  - Shadow is written to the current slot's committed registers.
  - If slot < 3: slot + 1, field = hour, shadow reloaded from the new slot.
  - If slot = 3: go to IDLE.
- key_sel: field = (field + 1) mod 3.
- key_inc / key_dec act on the edited field only, with wrap:
  - hour: 23 +1 → 0, 0 −1 → 23.
  - minute and second: 59 +1 → 0, 0 −1 → 59.
- key_clr: all three shadow fields = 0; field unchanged.
- Timeout:
  - The counter increments every EDIT cycle with no key pulse and clears on any key pulse.
  - On reaching TIMEOUT_CYC − 1: go to IDLE. The shadow is discarded and the current slot is not committed.
  - Slots committed earlier in the same session keep their new values.
- Blink:
  - In EDIT, a counter toggles blink every BLINK_CYC cycles.
  - Any key pulse forces blink = 1 and clears the blink counter.
  - Entering EDIT starts with blink = 1.
- Committed registers change only on key_mode in EDIT, or on rst.
- Shadow values are always kept in legal range; no out-of-range value is ever produced.

## Timing
- Reset: all alarmN_* = 0, state IDLE, edit_active = 0, edit_slot = 0, edit_field = 0, edit_* = 0, blink = 0, both counters = 0.
- All outputs are registered. Every key effect is visible on the cycle after the pulse (latency 1).
- Commit and slot reload happen in the same edge: after key_mode, alarmN_* holds the new value and edit_* shows slot N+1's committed values.
- rst mid-edit returns to the reset state on the next edge. Committed values are lost (reset to 0).
- Key pulses in IDLE other than key_mode are ignored.
- Back-to-back pulses on consecutive cycles are each honoured.

## Test plan
- Reset, then key_mode → edit_active = 1, edit_slot = 1, edit_field = 0, edit_* = 0, blink = 1 one cycle later.
- In EDIT on slot 1, hour: key_dec ×1 → edit_hour = 23. Then key_inc ×1 → 0. Then key_sel ×1, key_dec ×1 → edit_minute = 59. Then key_sel ×1, key_inc ×60 → edit_second = 0 (wraps).
- Enter EDIT, set slot 1 to 07:30:00, key_mode → alarm1 = 7/30/0, edit_slot = 2, edit_* = 0. Then key_mode ×2 → IDLE; alarm2 and alarm3 are unchanged.
- With TIMEOUT_CYC = 20: enter EDIT, key_inc ×3, idle 19 cycles → IDLE, alarm1 unchanged at 0. Repeat with a key pulse at idle cycle 15 → still in EDIT at cycle 19.
- Same cycle key_mode + key_inc with shadow 05:00:00 → alarm1_hour = 5 (inc ignored). Same cycle key_clr + key_inc → shadow 00:00:00.
- With BLINK_CYC = 4 in EDIT: blink toggles every 4 cycles. A key pulse mid-phase forces blink = 1 next cycle. Assert rst during EDIT → all outputs 0 next cycle.
